// File: rtl/uart_rx_cfg.sv
// UART receiver with runtime baud divisor, optional parity, 1/2 stop bits,
// 3-sample majority voting per bit and a receive FIFO with valid/ready read-out.
module uart_rx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    input  logic                          rx_en,
    input  logic [DIV_W-1:0]              cfg_div,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_perr,
    output logic                          rx_ferr,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          rx_overrun,
    input  logic                          ovr_clr,
    output logic                          rx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [2:0]                    dbg_state
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam int ENT_W = DATA_BITS + 2;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    state_t r_state, w_state_nxt;

    logic                 r_sync1, r_sync2;
    logic [DIV_W-1:0]     r_div, r_cnt;
    logic [1:0]           r_par;
    logic                 r_stop2;
    logic                 r_s0, r_s1;
    logic [DATA_BITS-1:0] r_shift;
    logic [BIT_W-1:0]     r_bit_idx;
    logic                 r_stop_idx;
    logic                 r_perr, r_ferr;

    logic                 w_rx;
    logic [DIV_W-1:0]     w_div_eff, w_half, w_s_lo, w_s_hi;
    logic                 w_bit_end, w_decide, w_maj;
    logic                 w_par_en, w_par_exp, w_last_data, w_last_stop;
    logic                 w_ferr_now, w_push;

    assign w_rx        = r_sync2;
    assign w_div_eff   = (cfg_div < DIV_W'(4)) ? DIV_W'(4) : cfg_div;
    assign w_half      = r_div >> 1;
    assign w_s_lo      = w_half - DIV_W'(1);
    assign w_s_hi      = w_half + DIV_W'(1);
    assign w_bit_end   = (r_cnt == r_div - DIV_W'(1));
    assign w_decide    = (r_cnt == w_s_hi);
    assign w_maj       = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
    assign w_par_en    = r_par[0] ^ r_par[1];
    assign w_par_exp   = (^r_shift) ^ r_par[1];
    assign w_last_data = (r_bit_idx == BIT_W'(DATA_BITS - 1));
    assign w_last_stop = ~r_stop2 | r_stop_idx;
    assign w_ferr_now  = r_ferr | ~w_maj;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // The final stop decision leaves STOP immediately so a back-to-back start bit is not missed.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        case (r_state)
            S_IDLE:      if (rx_en && !w_rx) w_state_nxt = S_START;
            S_START: begin
                if (w_decide && w_maj) w_state_nxt = S_IDLE;
                else if (w_bit_end)    w_state_nxt = S_DATA;
            end
            S_DATA:      if (w_bit_end && w_last_data) w_state_nxt = w_par_en ? S_PARITY : S_STOP;
            S_PARITY:    if (w_bit_end) w_state_nxt = S_STOP;
            S_STOP: begin
                if (w_decide && w_last_stop) begin
                    w_push      = 1'b1;
                    w_state_nxt = w_ferr_now ? S_WAIT_HIGH : S_IDLE;
                end
            end
            S_WAIT_HIGH: if (w_rx) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_div      <= DIV_W'(4);
            r_par      <= 2'b00;
            r_stop2    <= 1'b0;
            r_cnt      <= '0;
            r_s0       <= 1'b1;
            r_s1       <= 1'b1;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            if (r_state == S_IDLE || r_state == S_WAIT_HIGH) begin
                r_cnt      <= '0;
                r_bit_idx  <= '0;
                r_stop_idx <= 1'b0;
                r_perr     <= 1'b0;
                r_ferr     <= 1'b0;
                if (r_state == S_IDLE && w_state_nxt == S_START) begin
                    r_div   <= w_div_eff;
                    r_par   <= cfg_parity;
                    r_stop2 <= cfg_stop2;
                end
            end else begin
                r_cnt <= w_bit_end ? '0 : r_cnt + DIV_W'(1);
                if (r_cnt == w_s_lo) r_s0 <= w_rx;
                if (r_cnt == w_half) r_s1 <= w_rx;
                case (r_state)
                    S_DATA: begin
                        if (w_decide)  r_shift   <= {w_maj, r_shift[DATA_BITS-1:1]};
                        if (w_bit_end) r_bit_idx <= r_bit_idx + BIT_W'(1);
                    end
                    S_PARITY: if (w_decide) r_perr <= w_maj ^ w_par_exp;
                    S_STOP: begin
                        if (w_decide)  r_ferr     <= w_ferr_now;
                        if (w_bit_end) r_stop_idx <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_overrun;
    logic             w_full, w_pop, w_wr, w_drop;
    logic [ENT_W-1:0] w_head;

    assign w_full = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign w_pop  = (r_count != '0) & rx_ready;
    assign w_wr   = w_push & (~w_full | w_pop);
    assign w_drop = w_push & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= {r_shift, r_perr, w_ferr_now};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_wr && !w_pop)      r_count <= r_count + (PTR_W+1)'(1);
            else if (!w_wr && w_pop) r_count <= r_count - (PTR_W+1)'(1);
            // A drop in the same cycle as a clear keeps the flag set.
            if (w_drop)       r_overrun <= 1'b1;
            else if (ovr_clr) r_overrun <= 1'b0;
        end
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign rx_valid   = (r_count != '0);
    assign rx_data    = rx_valid ? w_head[ENT_W-1:2] : '0;
    assign rx_perr    = rx_valid & w_head[1];
    assign rx_ferr    = rx_valid & w_head[0];
    assign rx_overrun = r_overrun;
    assign rx_busy    = (r_state != S_IDLE);
    assign fifo_count = r_count;
    assign dbg_state  = r_state;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: expected words go into a queue as frames are
// sent; a monitor pops and compares whenever the consumer accepts a word.
module tb_uart_rx_cfg;
    localparam int BIT = 16;
    localparam int W   = 10;

    logic        clk, rst, rx, rx_en, cfg_stop2, rx_ready, ovr_clr;
    logic [15:0] cfg_div;
    logic [1:0]  cfg_parity;
    logic [7:0]  rx_data;
    logic        rx_perr, rx_ferr, rx_valid, rx_overrun, rx_busy;
    logic [2:0]  fifo_count;
    logic [2:0]  dbg_state;

    logic [W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    uart_rx_cfg #(.DATA_BITS(8), .DIV_W(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rx_en(rx_en), .cfg_div(cfg_div),
        .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .rx_data(rx_data),
        .rx_perr(rx_perr), .rx_ferr(rx_ferr), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .rx_overrun(rx_overrun), .ovr_clr(ovr_clr),
        .rx_busy(rx_busy), .fifo_count(fifo_count), .dbg_state(dbg_state)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // driver tasks
    task automatic send_bits(input logic [15:0] bits, input int n, input int gbit);
        for (int i = 0; i < n; i++) begin
            rx = bits[i];
            if (i == gbit) begin
                repeat (9) @(negedge clk);
                rx = ~bits[i];
                @(negedge clk);
                rx = bits[i];
                repeat (6) @(negedge clk);
            end else begin
                repeat (BIT) @(negedge clk);
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic has_par, input logic par_bit,
                              input logic two_stop, input logic stop2_val, input int gbit);
        logic [15:0] bits;
        int n;
        bits     = '0;
        bits[0]  = 1'b0;
        bits[8:1] = d;
        n = 9;
        if (has_par) begin
            bits[n] = par_bit;
            n++;
        end
        bits[n] = 1'b1;
        n++;
        if (two_stop) begin
            bits[n] = stop2_val;
            n++;
        end
        send_bits(bits, n, gbit);
    endtask

    // scoreboard monitor: samples between the driving negedge and the next posedge
    always @(negedge clk) begin
        logic [W-1:0] got, exp;
        #2;
        if (!rst && rx_valid && rx_ready) begin
            got = {rx_data, rx_perr, rx_ferr};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_word actual=%h required=none", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    failures++;
                    $display("FAIL rx_word actual=%h required=%h", got, exp);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; rx = 1'b1; rx_en = 1'b1; cfg_div = 16'd16; cfg_parity = 2'b00;
        cfg_stop2 = 1'b0; rx_ready = 1'b1; ovr_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_valid", rx_valid, 0);
        chk("reset_count", fifo_count, 0);
        chk("reset_busy", rx_busy, 0);
        chk("reset_overrun", rx_overrun, 0);
        chk("reset_data", rx_data, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // basic 8N1 frame with exact completion latency
        exp_q.push_back({8'hA5, 2'b00});
        fork
            send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1);
            begin
                int cyc;
                cyc = 0;
                while (cyc < 400 && !rx_valid) begin
                    @(negedge clk);
                    cyc++;
                end
                chk("basic_latency", cyc, 157);
                chk("basic_count", fifo_count, 1);
            end
        join
        repeat (10) @(negedge clk);

        // even parity: wrong then right parity bit; odd parity
        cfg_parity = 2'b01;
        exp_q.push_back({8'h07, 2'b10});
        send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        exp_q.push_back({8'h07, 2'b00});
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b1, -1);
        cfg_parity = 2'b10;
        exp_q.push_back({8'h03, 2'b00});
        send_frame(8'h03, 1'b1, 1'b1, 1'b0, 1'b1, -1);
        exp_q.push_back({8'h03, 2'b10});
        send_frame(8'h03, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        cfg_parity = 2'b00;
        repeat (10) @(negedge clk);

        // two stop bits: good frame, then bad second stop bit held low
        cfg_stop2 = 1'b1;
        exp_q.push_back({8'h81, 2'b00});
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        exp_q.push_back({8'h3C, 2'b01});
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        repeat (40) @(negedge clk);
        chk("ferr_wait_high_state", dbg_state, 5);
        chk("ferr_busy", rx_busy, 1);
        rx = 1'b1;
        repeat (6) @(negedge clk);
        chk("ferr_back_idle", dbg_state, 0);
        chk("ferr_not_busy", rx_busy, 0);
        cfg_stop2 = 1'b0;
        repeat (40) @(negedge clk);

        // 2-clock glitch on idle line
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("glitch_busy", rx_busy, 1);
        repeat (30) @(negedge clk);
        chk("glitch_idle", dbg_state, 0);
        chk("glitch_count", fifo_count, 0);

        // single-clock inversion mid data bit is voted out
        exp_q.push_back({8'hC3, 2'b00});
        send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 4);
        repeat (10) @(negedge clk);

        // rx_en low blocks start detection; dropping it mid-frame does not abort
        rx_en = 1'b0;
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        repeat (10) @(negedge clk);
        chk("rx_en_blocked_count", fifo_count, 0);
        rx_en = 1'b1;
        exp_q.push_back({8'h96, 2'b00});
        fork
            send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b1, -1);
            begin
                repeat (40) @(negedge clk);
                rx_en = 1'b0;
            end
        join
        rx_en = 1'b1;
        repeat (10) @(negedge clk);

        // overrun: five back-to-back frames into a 4-deep FIFO
        rx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back({8'(i), 2'b00});
            send_frame(8'(i), 1'b0, 1'b0, 1'b0, 1'b1, -1);
        end
        repeat (5) @(negedge clk);
        chk("ovr_count", fifo_count, 4);
        chk("ovr_flag", rx_overrun, 1);
        chk("ovr_head_stable", rx_data, 8'h01);
        rx_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("ovr_drained", fifo_count, 0);
        chk("ovr_sticky", rx_overrun, 1);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        chk("ovr_cleared", rx_overrun, 0);

        // reset mid-frame with a word parked in the FIFO
        rx_ready = 1'b0;
        send_frame(8'h77, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        repeat (5) @(negedge clk);
        chk("pre_reset_count", fifo_count, 1);
        send_bits({7'd0, 8'h5A, 1'b0}, 4, -1);
        rx = 1'b1 & 8'h5A >> 3;
        repeat (8) @(negedge clk);
        chk("mid_frame_busy", rx_busy, 1);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_mid_valid", rx_valid, 0);
        chk("rst_mid_count", fifo_count, 0);
        chk("rst_mid_data", rx_data, 0);
        chk("rst_mid_flags", {rx_perr, rx_ferr, rx_overrun, rx_busy}, 0);
        rst = 1'b0;
        rx_ready = 1'b1;
        repeat (5) @(negedge clk);
        exp_q.push_back({8'h5A, 2'b00});
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        repeat (20) @(negedge clk);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
